bus_pattern_checker: RTL and testbench

BUS_PATTERN_CHECKER -- requirements
Module: bus_pattern_checker

---
 rtl/bus_pattern_checker.sv | 195 +++++++++++++++++++
 tb/tb_bus_pattern_checker.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_pattern_checker.sv
// rtl/bus_pattern_checker.sv - checks frames of words written over an RPi parallel bus against a linear pattern
//
// Ports:
//   clk_100mhz  in   sole clock, rising edge
//   reset_n     in   synchronous active-low reset
//   bus_clk     in   bus strobe, asynchronous to clk_100mhz
//   bus_data    io   bus data; driven with the report word while raw bus_rnw = 1
//   bus_rnw     in   1 = master reads, 0 = master writes
//   led_out     out  low 4 bits of the last written word
//   led0_r      out  reset indicator (~reset_n)
//   led0_g      out  frame passed (REPORT state only)
//   led1_r      out  frame failed (REPORT state only)

module bus_pattern_checker #(
  parameter int DATA_W      = 8,
  parameter int FRAME_LEN   = 256,
  parameter int START_VAL   = 0,
  parameter int INCR        = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_100mhz,
  input  logic              reset_n,
  input  logic              bus_clk,
  inout  wire  [DATA_W-1:0] bus_data,
  input  logic              bus_rnw,
  output logic [3:0]        led_out,
  output logic              led0_r,
  output logic              led0_g,
  output logic              led1_r
);

  localparam logic [DATA_W-1:0] START_W  = DATA_W'(START_VAL);
  localparam logic [DATA_W-1:0] INCR_W   = DATA_W'(INCR);
  localparam logic [15:0]       LAST_IDX = 16'(FRAME_LEN - 1);
  localparam logic [15:0]       NO_ERR   = 16'hFFFF;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_RECV,
    S_REPORT
  } state_t;

  // Synchronisers: index 0 samples the pin, index SYNC_STAGES-1 is used.
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_rnw_sync;
  logic [DATA_W-1:0]      r_data_sync [SYNC_STAGES];
  logic                   r_clk_prev;

  state_t                 r_state;
  logic [15:0]            r_idx;
  logic [DATA_W-1:0]      r_expected;
  logic [15:0]            r_err_cnt;
  logic [15:0]            r_first_err;
  logic [2:0]             r_rpt_idx;
  logic [DATA_W-1:0]      r_rpt_data;
  logic [3:0]             r_led_out;
  logic                   r_led_g;
  logic                   r_led_r;

  logic                   w_clk_s;
  logic                   w_rnw_s;
  logic [DATA_W-1:0]      w_word;
  logic                   w_strobe;
  logic                   w_wr;
  logic                   w_rd;
  logic                   w_mismatch;
  logic                   w_new_mismatch;
  logic                   w_pass;
  logic [15:0]            w_err_inc;
  logic [DATA_W-1:0]      w_rpt_word;

  always_ff @(posedge clk_100mhz) begin
    if (!reset_n) begin
      r_clk_sync <= '0;
      r_rnw_sync <= '0;
      r_clk_prev <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_data_sync[i] <= '0;
      end
    end else begin
      r_clk_sync     <= {r_clk_sync[SYNC_STAGES-2:0], bus_clk};
      r_rnw_sync     <= {r_rnw_sync[SYNC_STAGES-2:0], bus_rnw};
      r_clk_prev     <= w_clk_s;
      r_data_sync[0] <= bus_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_data_sync[i] <= r_data_sync[i-1];
      end
    end
  end

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_rnw_s  = r_rnw_sync[SYNC_STAGES-1];
  assign w_word   = r_data_sync[SYNC_STAGES-1];
  assign w_strobe = w_clk_s & ~r_clk_prev;
  assign w_wr     = w_strobe & ~w_rnw_s;
  assign w_rd     = w_strobe &  w_rnw_s;

  assign w_mismatch     = (w_word != r_expected);
  // A write arriving in REPORT starts a fresh frame, so it is judged against START_VAL.
  assign w_new_mismatch = (w_word != START_W);
  assign w_pass         = (r_err_cnt == 16'd0);
  assign w_err_inc      = (r_err_cnt == 16'hFFFF) ? r_err_cnt : r_err_cnt + 16'd1;

  always_comb begin
    w_rpt_word = '0;
    case (r_rpt_idx)
      3'd0:    w_rpt_word = DATA_W'(w_pass);
      3'd1:    w_rpt_word = DATA_W'(r_err_cnt[7:0]);
      3'd2:    w_rpt_word = DATA_W'(r_err_cnt[15:8]);
      3'd3:    w_rpt_word = DATA_W'(r_first_err[7:0]);
      3'd4:    w_rpt_word = DATA_W'(r_first_err[15:8]);
      default: w_rpt_word = '0;
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (!reset_n) begin
      r_state     <= S_CLEAR;
      r_idx       <= '0;
      r_expected  <= START_W;
      r_err_cnt   <= '0;
      r_first_err <= NO_ERR;
      r_rpt_idx   <= '0;
      r_rpt_data  <= '0;
      r_led_out   <= '0;
      r_led_g     <= 1'b0;
      r_led_r     <= 1'b0;
    end else begin
      if (w_wr) begin
        r_led_out <= w_word[3:0];
      end

      // Report register and frame LEDs follow the current state one cycle later.
      r_rpt_data <= (r_state == S_REPORT) ? w_rpt_word : '0;
      r_led_g    <= (r_state == S_REPORT) &&  w_pass;
      r_led_r    <= (r_state == S_REPORT) && !w_pass;

      case (r_state)
        S_CLEAR: begin
          r_idx       <= '0;
          r_expected  <= START_W;
          r_err_cnt   <= '0;
          r_first_err <= NO_ERR;
          r_rpt_idx   <= '0;
          r_state     <= S_RECV;
        end

        S_RECV: begin
          if (w_wr) begin
            if (w_mismatch) begin
              r_err_cnt <= w_err_inc;
              if (r_first_err == NO_ERR) begin
                r_first_err <= r_idx;
              end
            end
            r_expected <= r_expected + INCR_W;
            r_idx      <= r_idx + 16'd1;
            if (r_idx == LAST_IDX) begin
              r_rpt_idx <= '0;
              r_state   <= S_REPORT;
            end
          end
        end

        S_REPORT: begin
          if (w_wr) begin
            r_err_cnt   <= w_new_mismatch ? 16'd1 : 16'd0;
            r_first_err <= w_new_mismatch ? 16'd0 : NO_ERR;
            r_expected  <= START_W + INCR_W;
            r_idx       <= 16'd1;
            r_rpt_idx   <= '0;
            r_state     <= (FRAME_LEN == 1) ? S_REPORT : S_RECV;
          end else if (w_rd) begin
            if (r_rpt_idx == 3'd4) begin
              r_state <= S_CLEAR;
            end else begin
              r_rpt_idx <= r_rpt_idx + 3'd1;
            end
          end
        end

        default: r_state <= S_CLEAR;
      endcase
    end
  end

  // Output enable uses the raw pin so the bus turns around without synchroniser lag.
  assign bus_data = bus_rnw ? r_rpt_data : {DATA_W{1'bz}};

  assign led_out = r_led_out;
  assign led0_g  = r_led_g;
  assign led1_r  = r_led_r;
  assign led0_r  = ~reset_n;

endmodule

// File: tb/tb_bus_pattern_checker.sv
// tb/tb_bus_pattern_checker.sv - directed self-checking bench for bus_pattern_checker

module tb_bus_pattern_checker;

  logic        clk;
  logic        reset_n;
  logic        bclk;
  logic        rnw;
  logic        oe;
  logic [15:0] wdata;
  logic        sel;

  int total;
  int bad;

  // Instance A: default parameters
  logic       bus_clk_a;
  logic       bus_rnw_a;
  wire  [7:0] bus_data_a;
  logic [3:0] led_out_a;
  logic       led0_r_a;
  logic       led0_g_a;
  logic       led1_r_a;

  // Instance B: 16-bit wrap configuration
  logic        bus_clk_b;
  logic        bus_rnw_b;
  wire  [15:0] bus_data_b;
  logic [3:0]  led_out_b;
  logic        led0_r_b;
  logic        led0_g_b;
  logic        led1_r_b;

  assign bus_clk_a  = (sel == 1'b0) & bclk;
  assign bus_rnw_a  = (sel == 1'b0) & rnw;
  assign bus_data_a = ((sel == 1'b0) && oe) ? wdata[7:0] : 8'bz;
  assign bus_clk_b  = (sel == 1'b1) & bclk;
  assign bus_rnw_b  = (sel == 1'b1) & rnw;
  assign bus_data_b = ((sel == 1'b1) && oe) ? wdata : 16'bz;

  bus_pattern_checker dut_a (
    .clk_100mhz (clk),
    .reset_n    (reset_n),
    .bus_clk    (bus_clk_a),
    .bus_data   (bus_data_a),
    .bus_rnw    (bus_rnw_a),
    .led_out    (led_out_a),
    .led0_r     (led0_r_a),
    .led0_g     (led0_g_a),
    .led1_r     (led1_r_a)
  );

  bus_pattern_checker #(
    .DATA_W    (16),
    .FRAME_LEN (4),
    .START_VAL (16'hFFFE),
    .INCR      (1)
  ) dut_b (
    .clk_100mhz (clk),
    .reset_n    (reset_n),
    .bus_clk    (bus_clk_b),
    .bus_data   (bus_data_b),
    .bus_rnw    (bus_rnw_b),
    .led_out    (led_out_b),
    .led0_r     (led0_r_b),
    .led0_g     (led0_g_b),
    .led1_r     (led1_r_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [15:0] d);
    rnw   = 1'b0;
    oe    = 1'b1;
    wdata = d;
    repeat (3) @(negedge clk);
    bclk = 1'b1;
    repeat (6) @(negedge clk);
    bclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_read(output logic [15:0] v);
    oe  = 1'b0;
    rnw = 1'b1;
    repeat (4) @(negedge clk);
    v = sel ? bus_data_b : {8'h00, bus_data_a};
    bclk = 1'b1;
    repeat (6) @(negedge clk);
    bclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Writes words first..first+n-1 as (index & 0xFF); indices bad0/bad1 are replaced by 0xAA.
  task automatic write_seq(input int first, input int n, input int bad0, input int bad1);
    for (int i = first; i < first + n; i++) begin
      if (i == bad0 || i == bad1) do_write(16'h00AA);
      else                        do_write(16'(i & 8'hFF));
    end
  endtask

  task automatic test_reset;
    logic [15:0] v;
    reset_n = 1'b0;
    sel = 1'b0;
    rnw = 1'b1;
    oe  = 1'b0;
    repeat (3) @(negedge clk);
    v = {8'h00, bus_data_a};
    total++; if (v !== 16'h0000) begin bad++; $display("FAIL reset_rpt_data got=%h want=0000", v); end
    total++; if (led0_r_a !== 1'b1) begin bad++; $display("FAIL reset_led0_r got=%b want=1", led0_r_a); end
    total++; if (led_out_a !== 4'h0) begin bad++; $display("FAIL reset_led_out got=%h want=0", led_out_a); end
    total++; if (led0_g_a !== 1'b0 || led1_r_a !== 1'b0) begin bad++; $display("FAIL reset_frame_leds got=%b%b want=00", led0_g_a, led1_r_a); end
    reset_n = 1'b1;
    rnw = 1'b0;
    repeat (6) @(negedge clk);
    total++; if (led0_r_a !== 1'b0) begin bad++; $display("FAIL release_led0_r got=%b want=0", led0_r_a); end
  endtask

  task automatic test_pass_frame;
    logic [15:0] v;
    logic [15:0] exp [5] = '{16'h1, 16'h0, 16'h0, 16'hFF, 16'hFF};
    write_seq(0, 256, -1, -1);
    total++; if (led0_g_a !== 1'b1) begin bad++; $display("FAIL pass_led0_g got=%b want=1", led0_g_a); end
    total++; if (led1_r_a !== 1'b0) begin bad++; $display("FAIL pass_led1_r got=%b want=0", led1_r_a); end
    total++; if (led_out_a !== 4'hF) begin bad++; $display("FAIL pass_led_out got=%h want=f", led_out_a); end
    for (int k = 0; k < 5; k++) begin
      do_read(v);
      total++; if (v !== exp[k]) begin bad++; $display("FAIL pass_read%0d got=%h want=%h", k, v, exp[k]); end
    end
    total++; if (led0_g_a !== 1'b0) begin bad++; $display("FAIL pass_after_report_led0_g got=%b want=0", led0_g_a); end
  endtask

  task automatic test_fail_frame;
    logic [15:0] v;
    logic [15:0] exp [5] = '{16'h0, 16'h2, 16'h0, 16'h0A, 16'h0};
    write_seq(0, 256, 10, 200);
    total++; if (led1_r_a !== 1'b1) begin bad++; $display("FAIL fail_led1_r got=%b want=1", led1_r_a); end
    total++; if (led0_g_a !== 1'b0) begin bad++; $display("FAIL fail_led0_g got=%b want=0", led0_g_a); end
    for (int k = 0; k < 5; k++) begin
      do_read(v);
      total++; if (v !== exp[k]) begin bad++; $display("FAIL fail_read%0d got=%h want=%h", k, v, exp[k]); end
    end
  endtask

  task automatic test_abandon_report;
    logic [15:0] v;
    logic [15:0] exp [5] = '{16'h1, 16'h0, 16'h0, 16'hFF, 16'hFF};
    write_seq(0, 256, 3, -1);
    do_read(v);
    total++; if (v !== 16'h0) begin bad++; $display("FAIL abandon_pre_read0 got=%h want=0000", v); end
    do_read(v);
    total++; if (v !== 16'h1) begin bad++; $display("FAIL abandon_pre_read1 got=%h want=0001", v); end
    write_seq(0, 256, -1, -1);
    total++; if (led0_g_a !== 1'b1) begin bad++; $display("FAIL abandon_led0_g got=%b want=1", led0_g_a); end
    for (int k = 0; k < 5; k++) begin
      do_read(v);
      total++; if (v !== exp[k]) begin bad++; $display("FAIL abandon_read%0d got=%h want=%h", k, v, exp[k]); end
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [15:0] v;
    logic [15:0] exp [5] = '{16'h1, 16'h0, 16'h0, 16'hFF, 16'hFF};
    write_seq(0, 100, -1, -1);
    reset_n = 1'b0;
    @(negedge clk);
    total++; if (led_out_a !== 4'h0) begin bad++; $display("FAIL midreset_led_out got=%h want=0", led_out_a); end
    total++; if (led0_r_a !== 1'b1) begin bad++; $display("FAIL midreset_led0_r got=%b want=1", led0_r_a); end
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    write_seq(0, 256, -1, -1);
    total++; if (led0_g_a !== 1'b1) begin bad++; $display("FAIL midreset_led0_g got=%b want=1", led0_g_a); end
    for (int k = 0; k < 5; k++) begin
      do_read(v);
      total++; if (v !== exp[k]) begin bad++; $display("FAIL midreset_read%0d got=%h want=%h", k, v, exp[k]); end
    end
  endtask

  task automatic test_reads_in_recv;
    logic [15:0] v;
    write_seq(0, 100, -1, -1);
    for (int k = 0; k < 3; k++) do_read(v);
    write_seq(100, 155, -1, -1);
    total++; if (led0_g_a !== 1'b0 || led1_r_a !== 1'b0) begin bad++; $display("FAIL recvread_early_report got=%b%b want=00", led0_g_a, led1_r_a); end
    do_write(16'h00FF);
    total++; if (led0_g_a !== 1'b1) begin bad++; $display("FAIL recvread_led0_g got=%b want=1", led0_g_a); end
    do_read(v);
    total++; if (v !== 16'h1) begin bad++; $display("FAIL recvread_read0 got=%h want=0001", v); end
    for (int k = 1; k < 5; k++) do_read(v);
    total++; if (v !== 16'hFF) begin bad++; $display("FAIL recvread_read4 got=%h want=00ff", v); end
  endtask

  task automatic test_wrap_16bit;
    logic [15:0] v;
    logic [15:0] exp [5] = '{16'h1, 16'h0, 16'h0, 16'hFF, 16'hFF};
    sel = 1'b1;
    do_write(16'hFFFE);
    do_write(16'hFFFF);
    do_write(16'h0000);
    do_write(16'h0001);
    total++; if (led0_g_b !== 1'b1) begin bad++; $display("FAIL wrap_led0_g got=%b want=1", led0_g_b); end
    total++; if (led_out_b !== 4'h1) begin bad++; $display("FAIL wrap_led_out got=%h want=1", led_out_b); end
    for (int k = 0; k < 5; k++) begin
      do_read(v);
      total++; if (v !== exp[k]) begin bad++; $display("FAIL wrap_read%0d got=%h want=%h", k, v, exp[k]); end
    end
    sel = 1'b0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    bclk    = 1'b0;
    rnw     = 1'b0;
    oe      = 1'b0;
    wdata   = '0;
    sel     = 1'b0;
    reset_n = 1'b0;
    test_reset();
    test_pass_frame();
    test_fail_frame();
    test_abandon_report();
    test_reset_mid_frame();
    test_reads_in_recv();
    test_wrap_16bit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
